// File: rtl/nn_eval_sequencer.sv
// rtl/nn_eval_sequencer.sv - on-chip NN accuracy evaluator with done/timeout handshake (optional MISS_LOG_EN first-miss capture)
module nn_eval_sequencer #(
    parameter int DATA_W    = 8,
    parameter int N_FEAT    = 62,
    parameter int N_SAMPLES = 750,
    parameter int LABEL_W   = 8,
    parameter int ADDR_W    = 16,
    parameter int CNT_W     = 32,
    parameter int TIMEOUT   = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       go,
    output logic                       mem_rd_en,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_rd_data,
    output logic                       lbl_rd_en,
    output logic [ADDR_W-1:0]          lbl_addr,
    input  logic [LABEL_W-1:0]         lbl_rd_data,
    output logic [N_FEAT*DATA_W-1:0]   nn_data,
    output logic                       nn_clr,
    output logic                       nn_start,
    input  logic                       nn_done,
    input  logic [LABEL_W-1:0]         nn_label,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           num_correct,
    output logic [CNT_W-1:0]           num_tested,
    output logic                       timeout_err
`ifdef MISS_LOG_EN
    ,
    output logic [ADDR_W-1:0]          first_miss_idx,
    output logic [LABEL_W-1:0]         first_miss_pred,
    output logic [LABEL_W-1:0]         first_miss_exp,
    output logic                       first_miss_vld
`endif
);

    localparam int J_W    = $clog2(N_FEAT + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [J_W-1:0]    J_LAST  = J_W'(N_FEAT);
    localparam logic [J_W-1:0]    J_ONE   = J_W'(1);
    localparam logic [WAIT_W-1:0] W_MAX   = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] W_ONE   = WAIT_W'(1);
    localparam logic [ADDR_W-1:0] LAST_S  = ADDR_W'(N_SAMPLES - 1);
    localparam logic [ADDR_W-1:0] A_STEP  = ADDR_W'(N_FEAT);
    localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CLR,
        S_RUN,
        S_CMP,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0]  s_idx;       // current sample index
    logic [ADDR_W-1:0]  addr_base;   // s_idx * N_FEAT, kept as a running sum
    logic [J_W-1:0]     j_cnt;       // FETCH cycle index, 0..N_FEAT
    logic [WAIT_W-1:0]  wait_cnt;    // RUN cycle number, 1-based
    logic [LABEL_W-1:0] exp_q;
    logic [LABEL_W-1:0] pred_q;
    logic               sample_to;   // current sample timed out

    logic start_run;
    logic run_timeout;
    logic sample_hit;
    logic last_sample;

    assign start_run   = ((state == S_IDLE) || (state == S_DONE)) && go;
    assign run_timeout = (state == S_RUN) && !nn_done && (wait_cnt == W_MAX);
    assign sample_hit  = (pred_q == exp_q) && !sample_to;
    assign last_sample = (s_idx == LAST_S);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; nn_done takes priority over the timeout on the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (go) state_nxt = S_FETCH;
            S_FETCH: if (j_cnt == J_LAST) state_nxt = S_CLR;
            S_CLR:   state_nxt = S_RUN;
            S_RUN:   if (nn_done || run_timeout) state_nxt = S_CMP;
            S_CMP:   state_nxt = last_sample ? S_DONE : S_FETCH;
            S_DONE:  if (go) state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode; read strobes only on the N_FEAT issue cycles, addresses zero otherwise
    always_comb begin
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        lbl_rd_en = 1'b0;
        lbl_addr  = '0;
        nn_clr    = 1'b0;
        nn_start  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_FETCH: begin
                busy = 1'b1;
                if (j_cnt != J_LAST) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = addr_base + ADDR_W'(j_cnt);
                end
                if (j_cnt == '0) begin
                    lbl_rd_en = 1'b1;
                    lbl_addr  = s_idx;
                end
            end
            S_CLR: begin
                busy   = 1'b1;
                nn_clr = 1'b1;
            end
            S_RUN: begin
                busy     = 1'b1;
                nn_start = 1'b1;
            end
            S_CMP:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: sample fetch/pack, run wait counting, scoring
    always_ff @(posedge clk) begin
        if (!rst) begin
            s_idx       <= '0;
            addr_base   <= '0;
            j_cnt       <= '0;
            wait_cnt    <= '0;
            exp_q       <= '0;
            pred_q      <= '0;
            sample_to   <= 1'b0;
            nn_data     <= '0;
            num_correct <= '0;
            num_tested  <= '0;
            timeout_err <= 1'b0;
`ifdef MISS_LOG_EN
            first_miss_idx  <= '0;
            first_miss_pred <= '0;
            first_miss_exp  <= '0;
            first_miss_vld  <= 1'b0;
`endif
        end else begin
            if (start_run) begin
                s_idx       <= '0;
                addr_base   <= '0;
                j_cnt       <= '0;
                num_correct <= '0;
                num_tested  <= '0;
                timeout_err <= 1'b0;
`ifdef MISS_LOG_EN
                first_miss_idx  <= '0;
                first_miss_pred <= '0;
                first_miss_exp  <= '0;
                first_miss_vld  <= 1'b0;
`endif
            end
            case (state)
                S_FETCH: begin
                    j_cnt <= j_cnt + J_ONE;
                    // Byte issued on cycle j returns on cycle j+1 into slot j
                    for (int k = 0; k < N_FEAT; k++) begin
                        if (j_cnt == J_W'(k + 1)) begin
                            nn_data[k*DATA_W +: DATA_W] <= mem_rd_data;
                        end
                    end
                    if (j_cnt == J_ONE) begin
                        exp_q <= lbl_rd_data;
                    end
                end
                S_CLR: begin
                    j_cnt     <= '0;
                    wait_cnt  <= W_ONE;
                    sample_to <= 1'b0;
                end
                S_RUN: begin
                    if (nn_done) begin
                        pred_q <= nn_label;
                    end else if (wait_cnt == W_MAX) begin
                        sample_to   <= 1'b1;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + W_ONE;
                    end
                end
                S_CMP: begin
                    num_tested <= num_tested + CNT_ONE;
                    if (sample_hit) begin
                        num_correct <= num_correct + CNT_ONE;
                    end
                    if (!last_sample) begin
                        s_idx     <= s_idx + A_ONE;
                        addr_base <= addr_base + A_STEP;
                    end
`ifdef MISS_LOG_EN
                    if (!sample_hit && !first_miss_vld) begin
                        first_miss_vld  <= 1'b1;
                        first_miss_idx  <= s_idx;
                        first_miss_exp  <= exp_q;
                        first_miss_pred <= sample_to ? {LABEL_W{1'b1}} : pred_q;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_eval_sequencer.sv
// tb/tb_nn_eval_sequencer.sv - directed self-checking bench for nn_eval_sequencer
module tb_nn_eval_sequencer;

    localparam int DATA_W    = 8;
    localparam int N_FEAT    = 4;
    localparam int N_SAMPLES = 3;
    localparam int LABEL_W   = 8;
    localparam int ADDR_W    = 16;
    localparam int CNT_W     = 32;
    localparam int TIMEOUT   = 10;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     go  = 1'b0;
    logic                     mem_rd_en;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_rd_data = '0;
    logic                     lbl_rd_en;
    logic [ADDR_W-1:0]        lbl_addr;
    logic [LABEL_W-1:0]       lbl_rd_data = '0;
    logic [N_FEAT*DATA_W-1:0] nn_data;
    logic                     nn_clr;
    logic                     nn_start;
    logic                     nn_done;
    logic [LABEL_W-1:0]       nn_label;
    logic                     busy;
    logic                     done;
    logic [CNT_W-1:0]         num_correct;
    logic [CNT_W-1:0]         num_tested;
    logic                     timeout_err;
`ifdef MISS_LOG_EN
    logic [ADDR_W-1:0]        first_miss_idx;
    logic [LABEL_W-1:0]       first_miss_pred;
    logic [LABEL_W-1:0]       first_miss_exp;
    logic                     first_miss_vld;
`endif

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0]  smem    [0:N_FEAT*N_SAMPLES-1];
    logic [LABEL_W-1:0] exp_lbl [0:N_SAMPLES-1];
    logic [LABEL_W-1:0] pred_lbl[0:N_SAMPLES-1];
    int                 dly     [0:N_SAMPLES-1];
    int                 run_cyc = 0;
    int                 cur_s   = 0;
    int                 addr_log[$];

    always #5 clk = ~clk;

    nn_eval_sequencer #(
        .DATA_W(DATA_W), .N_FEAT(N_FEAT), .N_SAMPLES(N_SAMPLES), .LABEL_W(LABEL_W),
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .go(go),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .lbl_rd_en(lbl_rd_en), .lbl_addr(lbl_addr), .lbl_rd_data(lbl_rd_data),
        .nn_data(nn_data), .nn_clr(nn_clr), .nn_start(nn_start),
        .nn_done(nn_done), .nn_label(nn_label),
        .busy(busy), .done(done), .num_correct(num_correct), .num_tested(num_tested),
        .timeout_err(timeout_err)
`ifdef MISS_LOG_EN
        ,
        .first_miss_idx(first_miss_idx), .first_miss_pred(first_miss_pred),
        .first_miss_exp(first_miss_exp), .first_miss_vld(first_miss_vld)
`endif
    );

    // Memory and NN core models
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= smem[mem_addr];
        if (lbl_rd_en) begin
            lbl_rd_data <= exp_lbl[lbl_addr];
            cur_s       <= int'(lbl_addr);
        end
        if (nn_clr)        run_cyc <= 1;
        else if (nn_start) run_cyc <= run_cyc + 1;
        else               run_cyc <= 0;
    end

    assign nn_done  = nn_start && (dly[cur_s] != 0) && (run_cyc == dly[cur_s]);
    assign nn_label = pred_lbl[cur_s];

    always @(negedge clk) begin
        if (mem_rd_en === 1'b1) addr_log.push_back(int'(mem_addr));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nominal();
        for (int k = 0; k < N_FEAT*N_SAMPLES; k++) smem[k] = 8'(8'h11 * (k + 1));
        exp_lbl[0] = 8'd3; exp_lbl[1] = 8'd7; exp_lbl[2] = 8'd1;
        for (int k = 0; k < N_SAMPLES; k++) begin
            pred_lbl[k] = exp_lbl[k];
            dly[k]      = 5;
        end
    endtask

    task automatic do_run(output int cyc);
        go = 1'b1;
        tick();
        go  = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 2000) begin
            tick();
            cyc++;
        end
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL run_bound: done=%b after %0d cycles, required 1", done, cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        tests++;
        if ({busy, done, timeout_err, mem_rd_en, lbl_rd_en, nn_clr, nn_start} !== 7'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b, required 0", {busy, done, timeout_err, mem_rd_en, lbl_rd_en, nn_clr, nn_start});
        end
        tests++;
        if (num_correct !== 0 || num_tested !== 0 || nn_data !== 0 || mem_addr !== 0) begin
            fails++;
            $display("FAIL reset_values: correct=%0d tested=%0d nn_data=%h addr=%0d, required 0", num_correct, num_tested, nn_data, mem_addr);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_all_correct();
        int cyc;
        set_nominal();
        addr_log.delete();
        do_run(cyc);
        tests++;
        if (num_correct !== 3 || num_tested !== 3 || timeout_err !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL all_correct: correct=%0d tested=%0d to=%b busy=%b, required 3 3 0 0", num_correct, num_tested, timeout_err, busy);
        end
        tests++;
        if (cyc != 36) begin
            fails++;
            $display("FAIL all_correct_cycles: got %0d, required 36", cyc);
        end
        tests++;
        begin
            bool_chk: begin
                bit bad = (addr_log.size() != 12);
                for (int k = 0; k < addr_log.size() && k < 12; k++) if (addr_log[k] != k) bad = 1'b1;
                if (bad) begin
                    fails++;
                    $display("FAIL addr_seq: %0d addresses logged, required 0..11 in order", addr_log.size());
                end
            end
        end
        for (int k = 0; k < 5; k++) tick();
        tests++;
        if (done !== 1'b1 || num_correct !== 3 || nn_data !== 32'hCCBBAA99) begin
            fails++;
            $display("FAIL done_hold: done=%b correct=%0d nn_data=%h, required 1 3 ccbbaa99", done, num_correct, nn_data);
        end
    endtask

    task automatic test_packing();
        int n;
        set_nominal();
        go = 1'b1;
        tick();
        go = 1'b0;
        n = 0;
        while (nn_clr !== 1'b1 && n < 100) begin tick(); n++; end
        tests++;
        if (nn_data !== 32'h44332211) begin
            fails++;
            $display("FAIL pack_clr: got %h, required 44332211", nn_data);
        end
        tick();
        tests++;
        if (nn_start !== 1'b1 || nn_data !== 32'h44332211) begin
            fails++;
            $display("FAIL pack_s0: start=%b nn_data=%h, required 1 44332211", nn_start, nn_data);
        end
        n = 0;
        while (nn_start === 1'b1 && n < 100) begin tick(); n++; end
        while (nn_start !== 1'b1 && n < 200) begin tick(); n++; end
        tests++;
        if (nn_data !== 32'h88776655) begin
            fails++;
            $display("FAIL pack_s1: got %h, required 88776655", nn_data);
        end
        n = 0;
        while (done !== 1'b1 && n < 200) begin tick(); n++; end
        tests++;
        if (done !== 1'b1 || num_correct !== 3) begin
            fails++;
            $display("FAIL pack_run_end: done=%b correct=%0d, required 1 3", done, num_correct);
        end
    endtask

    task automatic test_wrong_label();
        int cyc;
        set_nominal();
        pred_lbl[1] = 8'd9;
        do_run(cyc);
        tests++;
        if (num_correct !== 2 || num_tested !== 3 || timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL wrong_label: correct=%0d tested=%0d to=%b, required 2 3 0", num_correct, num_tested, timeout_err);
        end
`ifdef MISS_LOG_EN
        tests++;
        if (first_miss_vld !== 1'b1 || first_miss_idx !== 1 || first_miss_pred !== 8'd9 || first_miss_exp !== 8'd7) begin
            fails++;
            $display("FAIL miss_wrong: vld=%b idx=%0d pred=%0d exp=%0d, required 1 1 9 7", first_miss_vld, first_miss_idx, first_miss_pred, first_miss_exp);
        end
`endif
    endtask

    task automatic test_timeout();
        int cyc;
        set_nominal();
        dly[0] = 0;
        do_run(cyc);
        tests++;
        if (num_correct !== 2 || num_tested !== 3 || timeout_err !== 1'b1) begin
            fails++;
            $display("FAIL timeout: correct=%0d tested=%0d to=%b, required 2 3 1", num_correct, num_tested, timeout_err);
        end
        tests++;
        if (cyc != 41) begin
            fails++;
            $display("FAIL timeout_cycles: got %0d, required 41", cyc);
        end
`ifdef MISS_LOG_EN
        tests++;
        if (first_miss_vld !== 1'b1 || first_miss_idx !== 0 || first_miss_pred !== 8'hFF || first_miss_exp !== 8'd3) begin
            fails++;
            $display("FAIL miss_timeout: vld=%b idx=%0d pred=%h exp=%0d, required 1 0 ff 3", first_miss_vld, first_miss_idx, first_miss_pred, first_miss_exp);
        end
`endif
    endtask

    task automatic test_done_at_timeout();
        int cyc;
        set_nominal();
        dly[0] = TIMEOUT;
        do_run(cyc);
        tests++;
        if (num_correct !== 3 || timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL done_at_limit: correct=%0d to=%b, required 3 0", num_correct, timeout_err);
        end
        tests++;
        if (cyc != 41) begin
            fails++;
            $display("FAIL done_at_limit_cycles: got %0d, required 41", cyc);
        end
    endtask

    task automatic test_go_ignored();
        int cyc;
        set_nominal();
        go = 1'b1;
        tick();
        go  = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 2000) begin
            if (cyc == 8) go = 1'b1;
            if (cyc == 9) go = 1'b0;
            tick();
            cyc++;
        end
        go = 1'b0;
        tests++;
        if (cyc != 36 || num_tested !== 3 || num_correct !== 3) begin
            fails++;
            $display("FAIL go_ignored: cycles=%0d tested=%0d correct=%0d, required 36 3 3", cyc, num_tested, num_correct);
        end
    endtask

    task automatic test_reset_midrun();
        int n;
        set_nominal();
        go = 1'b1;
        tick();
        go = 1'b0;
        n = 0;
        while (!(mem_rd_en === 1'b1 && mem_addr === 16'd5) && n < 200) begin tick(); n++; end
        tests++;
        if (mem_addr !== 16'd5 || num_tested !== 1) begin
            fails++;
            $display("FAIL midrun_reach: addr=%0d tested=%0d, required 5 1", mem_addr, num_tested);
        end
        rst = 1'b0;
        tick();
        tests++;
        if ({busy, done, timeout_err, mem_rd_en, lbl_rd_en, nn_clr, nn_start} !== 7'b0
            || num_tested !== 0 || num_correct !== 0 || nn_data !== 0 || mem_addr !== 0) begin
            fails++;
            $display("FAIL midrun_reset: flags=%b tested=%0d correct=%0d nn_data=%h addr=%0d, required all 0",
                     {busy, done, timeout_err, mem_rd_en, lbl_rd_en, nn_clr, nn_start}, num_tested, num_correct, nn_data, mem_addr);
        end
        rst = 1'b1;
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        tests++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 0 || lbl_rd_en !== 1'b1 || lbl_addr !== 0) begin
            fails++;
            $display("FAIL restart_addr: rd=%b addr=%0d lrd=%b laddr=%0d, required 1 0 1 0", mem_rd_en, mem_addr, lbl_rd_en, lbl_addr);
        end
        n = 0;
        while (done !== 1'b1 && n < 2000) begin tick(); n++; end
        tests++;
        if (done !== 1'b1 || num_tested !== 3 || num_correct !== 3) begin
            fails++;
            $display("FAIL restart_run: done=%b tested=%0d correct=%0d, required 1 3 3", done, num_tested, num_correct);
        end
    endtask

    initial begin
        set_nominal();
        test_reset();
        test_all_correct();
        test_packing();
        test_wrong_label();
        test_timeout();
        test_done_at_timeout();
        test_go_ignored();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nn_eval_sequencer.md
Name: nn_eval_sequencer

Overview:
On-chip accuracy evaluator for the NN core. It streams N_SAMPLES test vectors from sample/label memories into the NN, starts the NN and waits for its done, then compares the predicted label against the expected label and counts correct predictions. It replaces bench-side fixed-cycle stepping with a done/timeout handshake. It is parametrised in feature count, data width, sample count and timeout.

Parameters:
DATA_W, 8, width of one feature/weight byte
N_FEAT, 62, features per sample
N_SAMPLES, 750, samples per run (>=1, < 2^CNT_W)
LABEL_W, 8, label width
ADDR_W, 16, sample memory address width (must hold N_SAMPLES*N_FEAT-1)
CNT_W, 32, counter width
TIMEOUT, 1023, max cycles waiting for nn_done per sample

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
go  in  1  start a run; 1-cycle pulse or level, sampled only in IDLE/DONE
mem_rd_en  out  1  sample memory read strobe
mem_addr  out  ADDR_W  sample memory word address
mem_rd_data  in  DATA_W  read data, valid 1 cycle after mem_rd_en
lbl_rd_en  out  1  label memory read strobe
lbl_addr  out  ADDR_W  label address = sample index
lbl_rd_data  in  LABEL_W  valid 1 cycle after lbl_rd_en
nn_data  out  N_FEAT*DATA_W  packed sample; feature j at [j*DATA_W +: DATA_W]
nn_clr  out  1  1-cycle active-high clear pulse to NN core
nn_start  out  1  held high while NN runs
nn_done  in  1  NN result valid (level)
nn_label  in  LABEL_W  NN prediction
busy  out  1  run in progress
done  out  1  run finished, held until next go or reset
num_correct  out  CNT_W  correct predictions in current/last run
num_tested  out  CNT_W  samples completed
timeout_err  out  1  sticky: at least one sample timed out this run

Behaviour:
- Reset (rst=0 at edge): state IDLE; all outputs 0 incl. nn_data, counters, flags. Reset mid-run aborts immediately; no partial result is kept.
- States: IDLE, FETCH, CLR, RUN, CMP, DONE.
- IDLE/DONE + go=1: clear num_correct, num_tested, timeout_err, done; sample index s=0; busy=1; goto FETCH.
- FETCH: issue mem_rd_en with mem_addr = s*N_FEAT+j for j=0..N_FEAT-1, one per cycle. Capture each returned byte into nn_data slot j one cycle later. Assert lbl_rd_en with lbl_addr=s in the first FETCH cycle and latch the expected label. FETCH lasts N_FEAT+1 cycles (last cycle drains data), then goes to CLR.
- CLR: nn_clr=1 for exactly one cycle; goto RUN.
- RUN: nn_start=1. A wait counter increments each cycle.
  - nn_done=1: latch nn_label; goto CMP.
  - Wait counter == TIMEOUT without nn_done: set timeout_err; mark sample incorrect; goto CMP.
  - nn_done seen in the same cycle the counter hits TIMEOUT: done wins (not a timeout).
- CMP (1 cycle): nn_start=0. If latched prediction == expected and no timeout, num_correct+1. num_tested+1. If s==N_SAMPLES-1 goto DONE, else s+1 and goto FETCH.
- DONE: busy=0, done=1. Counters and nn_data hold.
- go while busy: ignored.
- nn_data changes only during FETCH. It is stable throughout CLR/RUN.
- Counters never wrap within a legal run (parameter constraint).
- Cycles per sample = N_FEAT+1 + 1 + t_run + 1, where t_run = cycles until nn_done (>=1).

Optional Feature:
MISS_LOG_EN: when defined, adds outputs first_miss_idx (ADDR_W), first_miss_pred (LABEL_W), first_miss_exp (LABEL_W) and first_miss_vld (1). These capture the first incorrect or timed-out sample of a run; they are cleared on go/reset and held until the next go. On a timeout, first_miss_pred records the all-ones value. When not defined, these ports and their registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then go, N_FEAT=4, N_SAMPLES=3, model NN returns done 5 cycles after nn_clr with correct labels -> done=1, num_correct=3, num_tested=3, timeout_err=0; mem_addr sequence 0..11.
- Same setup, sample 1 returns a wrong label -> num_correct=2, num_tested=3. With MISS_LOG_EN: first_miss_idx=1, first_miss_vld=1.
- TIMEOUT=10, model never asserts done for sample 0 -> RUN exits after 10 cycles, timeout_err=1, num_correct=2, run completes.
- nn_done asserted exactly on wait cycle TIMEOUT with correct label -> counted correct, timeout_err=0.
- go pulsed during RUN -> ignored. rst=0 during sample 1 FETCH -> next cycle all outputs 0, state IDLE. A fresh go restarts from mem_addr=0.
- Check nn_data packing: memory bytes 0x11,0x22,0x33,0x44 -> nn_data=0x44332211 while nn_start=1.
